lsu_mem_stage: RTL and testbench

- MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory control (is_load, mem_wren, mem_op, ALU address, rs2 data) and drives a req/gnt/rvalid data-bus port.
- Produces byte enables and replicated store data, and returns aligned, sign- or zero-extended load data to the MEM/WB register.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/lsu_mem_stage_pkg.sv | 18 +
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_mem_stage.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared pipeline definitions for the MEM-stage load/store unit.
// Memory operation encodings and the LSU state machine states.
package lsu_mem_stage_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/data, load extraction
// and extension, and misalignment detection.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  offs,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata_q,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic        is_b;
    logic        is_h;
    logic        uns;
    logic [31:0] shifted;

    // Undefined encodings fall through as word accesses.
    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        uns  = 1'b0;
        case (mem_op)
            MEM_B:  is_b = 1'b1;
            MEM_BU: begin is_b = 1'b1; uns = 1'b1; end
            MEM_H:  is_h = 1'b1;
            MEM_HU: begin is_h = 1'b1; uns = 1'b1; end
            MEM_W:  ;
            default: ;
        endcase
    end

    always_comb begin
        be       = 4'b1111;
        wdata    = st_data;
        misalign = |offs;
        if (is_b) begin
            be       = 4'b0001 << offs;
            wdata    = {4{st_data[7:0]}};
            misalign = 1'b0;
        end else if (is_h) begin
            be       = offs[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{st_data[15:0]}};
            misalign = offs[0];
        end
    end

    assign shifted = rdata_q >> {offs, 3'b000};

    always_comb begin
        ld_data = shifted;
        if (is_b)
            ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
        else if (is_h)
            ld_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master with
// timeout, misalign trap and pipeline stall generation.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        is_load_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;

    logic        mem_acc;
    logic        is_st;
    logic        tmo;
    logic        in_req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_ext;
    logic        misalign;

    assign mem_acc = is_load_i | mem_wren_i;
    assign is_st   = mem_wren_i & ~is_load_i;
    assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_align u_align (
        .mem_op   (mem_op_i),
        .offs     (addr_i[1:0]),
        .st_data  (st_data_i),
        .rdata_q  (data_q),
        .be       (be),
        .wdata    (wdata),
        .ld_data  (ld_ext),
        .misalign (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (mem_acc && misalign) begin
                    state_d = LSU_DONE;
                    mis_d   = 1'b1;
                    data_d  = '0;
                end else if (mem_acc) begin
                    state_d = LSU_REQ;
                    cnt_d   = '0;
                end
            end
            LSU_REQ: begin
                if (gnt_i && is_st) begin
                    state_d = LSU_DONE;
                    data_d  = '0;
                end else if (gnt_i && rvalid_i) begin
                    state_d = LSU_DONE;
                    data_d  = rdata_i;
                end else if (gnt_i) begin
                    state_d = LSU_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else if (tmo) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_WAIT: begin
                if (rvalid_i) begin
                    state_d = LSU_DONE;
                    data_d  = rdata_i;
                end else if (tmo) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign in_req     = state_q == LSU_REQ;
    assign done_o     = state_q == LSU_DONE;
    assign req_o      = in_req;
    assign we_o       = in_req & is_st;
    assign addr_o     = in_req ? {addr_i[31:2], 2'b00} : '0;
    assign be_o       = in_req ? be : '0;
    assign wdata_o    = (in_req && is_st) ? wdata : '0;
    assign ld_data_o  = done_o ? ld_ext : '0;
    assign misalign_o = done_o & mis_q;
    assign bus_err_o  = done_o & err_q;
    // Gated by reset so the stall is also low while rst_ni is held.
    assign stall_o    = rst_ni & mem_acc & ~done_o;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
// Drives after the rising edge, samples on the falling edge.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        is_load = 1'b0;
    logic        mem_wren = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] st_data = '0;
    logic        req_o, we_o;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] ld_data_o;
    logic        stall_o, done_o, misalign_o, bus_err_o;

    int total = 0;
    int passed = 0;

    int          r_stalls, r_reqs;
    logic        r_done, r_mis, r_err, r_we;
    logic [31:0] r_ld, r_addr, r_wd;
    logic [3:0]  r_be;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .is_load_i  (is_load),
        .mem_wren_i (mem_wren),
        .mem_op_i   (mem_op),
        .addr_i     (addr),
        .st_data_i  (st_data),
        .req_o      (req_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .be_o       (be_o),
        .wdata_o    (wdata_o),
        .gnt_i      (gnt),
        .rvalid_i   (rvalid),
        .rdata_i    (rdata),
        .ld_data_o  (ld_data_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Runs one access with a simple bus responder; called just after a rising edge.
    task automatic do_access(input logic ld, input logic st,
                             input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd,
                             input int rv_dly, input logic give_gnt);
        bit granted = 0;
        int wc = 0;
        is_load  = ld;
        mem_wren = st;
        mem_op   = op;
        addr     = a;
        st_data  = sd;
        rdata    = rd;
        r_stalls = 0;
        r_reqs   = 0;
        r_done   = 1'b0;
        r_mis    = 1'b0;
        r_err    = 1'b0;
        r_ld     = 'x;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            gnt    = 1'b0;
            rvalid = 1'b0;
            if (done_o) begin
                r_done = 1'b1;
                r_ld   = ld_data_o;
                r_mis  = misalign_o;
                r_err  = bus_err_o;
                break;
            end
            if (stall_o) r_stalls++;
            if (req_o) begin
                r_reqs++;
                r_be   = be_o;
                r_wd   = wdata_o;
                r_addr = addr_o;
                r_we   = we_o;
            end
            if (req_o && give_gnt) begin
                gnt     = 1'b1;
                granted = 1;
                wc      = 0;
                if (rv_dly == 0) rvalid = 1'b1;
            end else if (granted) begin
                wc++;
                if (wc == rv_dly) rvalid = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        is_load  = 1'b0;
        mem_wren = 1'b0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] rd,
                           input int rv_dly, input logic [31:0] exp);
        do_access(1'b1, 1'b0, op, a, '0, rd, rv_dly, 1'b1);
        chk({tag, "_done"}, 32'(r_done), 32'd1);
        chk({tag, "_data"}, r_ld, exp);
    endtask

    initial begin
        is_load = 1'b1;
        #12;
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ld", ld_data_o, 32'd0);
        chk("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
        is_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(1'b0, 1'b1, MEM_B, 32'h1003, 32'h0000_00A5, '0, 0, 1'b1);
        chk("sb_done", 32'(r_done), 32'd1);
        chk("sb_be", 32'(r_be), 32'h8);
        chk("sb_wdata", r_wd, 32'hA5A5_A5A5);
        chk("sb_addr", r_addr, 32'h1000);
        chk("sb_we", 32'(r_we), 32'd1);
        chk("sb_stalls", 32'(r_stalls), 32'd2);

        do_access(1'b0, 1'b1, MEM_H, 32'h1002, 32'h1234_ABCD, '0, 0, 1'b1);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wd, 32'hABCD_ABCD);

        do_access(1'b0, 1'b1, MEM_W, 32'h1004, 32'hDEAD_BEEF, '0, 1, 1'b1);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_wdata", r_wd, 32'hDEAD_BEEF);
        chk("sw_addr", r_addr, 32'h1004);

        do_load("lb", MEM_B, 32'h2002, 32'h12F4_5678, 3, 32'hFFFF_FFF4);
        chk("lb_stalls", 32'(r_stalls), 32'd5);
        chk("lb_be", 32'(r_be), 32'h4);
        chk("lb_we", 32'(r_we), 32'd0);
        do_load("lhu", MEM_HU, 32'h2002, 32'h12F4_5678, 1, 32'h0000_12F4);
        do_load("lbu", MEM_BU, 32'h2001, 32'h12F4_5678, 2, 32'h0000_0056);
        do_load("lb3", MEM_B, 32'h2003, 32'h12F4_5678, 1, 32'h0000_0012);
        do_load("lh_neg", MEM_H, 32'h2000, 32'h8001_FFFF, 1, 32'hFFFF_FFFF);
        do_load("lhu_neg", MEM_HU, 32'h2000, 32'h8001_FFFF, 2, 32'h0000_FFFF);
        do_load("lw_same", MEM_W, 32'h2000, 32'h8001_FFFF, 0, 32'h8001_FFFF);

        do_access(1'b1, 1'b0, MEM_W, 32'h3001, '0, 32'hFFFF_FFFF, 0, 1'b1);
        chk("mis_lw_flag", 32'(r_mis), 32'd1);
        chk("mis_lw_req", 32'(r_reqs), 32'd0);
        chk("mis_lw_ld", r_ld, 32'd0);
        chk("mis_lw_stalls", 32'(r_stalls), 32'd1);

        do_access(1'b0, 1'b1, MEM_H, 32'h1001, 32'h55, '0, 0, 1'b1);
        chk("mis_sh_flag", 32'(r_mis), 32'd1);
        chk("mis_sh_req", 32'(r_reqs), 32'd0);

        do_access(1'b1, 1'b0, 3'b011, 32'h2002, '0, '0, 0, 1'b1);
        chk("undef_op_mis", 32'(r_mis), 32'd1);

        do_access(1'b1, 1'b0, MEM_W, 32'h5000, '0, 32'h1111_1111, 0, 1'b0);
        chk("tmo_done", 32'(r_done), 32'd1);
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_req_cycles", 32'(r_reqs), 32'd64);
        chk("tmo_ld", r_ld, 32'd0);
        chk("tmo_stalls", 32'(r_stalls), 32'd65);
        @(negedge clk);
        chk("tmo_pulse", 32'(bus_err_o), 32'd0);
        chk("tmo_release", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;

        is_load = 1'b1;
        mem_op  = MEM_W;
        addr    = 32'h4000;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mr_req", 32'(req_o), 32'd1);
        gnt = 1'b1;
        @(posedge clk);
        #1;
        gnt = 1'b0;
        @(negedge clk);
        chk("mr_wait_stall", 32'(stall_o), 32'd1);
        rst_n   = 1'b0;
        is_load = 1'b0;
        #1;
        chk("mr_rst_req", 32'(req_o), 32'd0);
        chk("mr_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_DEAD;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mr_stale_done", 32'(done_o), 32'd0);
        chk("mr_stale_req", 32'(req_o), 32'd0);
        rvalid = 1'b0;
        @(posedge clk);
        #1;
        do_load("mr_next_lw", MEM_W, 32'h4004, 32'hCAFE_BABE, 2, 32'hCAFE_BABE);
        chk("mr_next_stalls", 32'(r_stalls), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
